// File: rtl/fsic_io_serdes_pkg.sv
// fsic_io_serdes_pkg: shared defaults and transmit FSM encoding for the FSIC IO serdes
package fsic_io_serdes_pkg;

    localparam int CLK_RATIO_DEFAULT    = 4;
    localparam int TXFIFO_DEPTH_DEFAULT = 2;

    // Filler word driven onto the pad when the holding FIFO runs dry at a word boundary
    localparam logic [CLK_RATIO_DEFAULT-1:0] IDLE_WORD_DEFAULT = '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } tx_state_e;

endpackage

// File: rtl/fsic_io_serdes_tx_fifo.sv
// fsic_io_serdes_tx_fifo: small synchronous holding FIFO for parallel transmit words
module fsic_io_serdes_tx_fifo #(
    parameter int pWIDTH = 4,
    parameter int pDEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [pWIDTH-1:0] din,
    output logic              full,
    output logic              empty,
    output logic [pWIDTH-1:0] dout
);

    localparam int PW = (pDEPTH > 1) ? $clog2(pDEPTH) : 1;
    localparam int CW = $clog2(pDEPTH + 1);

    logic [pWIDTH-1:0] mem_q [pDEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              do_push, do_pop;

    assign full    = count_q == CW'(pDEPTH);
    assign empty   = count_q == '0;
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointer advance with explicit wrap so non-power-of-2 depths work; occupancy tracks push minus pop
    always_comb begin
        wr_ptr_d = do_push ? ((wr_ptr_q == PW'(pDEPTH - 1)) ? '0 : wr_ptr_q + PW'(1)) : wr_ptr_q;
        rd_ptr_d = do_pop  ? ((rd_ptr_q == PW'(pDEPTH - 1)) ? '0 : rd_ptr_q + PW'(1)) : rd_ptr_q;
        count_d  = (do_push && !do_pop) ? count_q + CW'(1) :
                   (do_pop && !do_push) ? count_q - CW'(1) : count_q;
    end

    // Control state; reset flushes the FIFO by clearing pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array needs no reset: entries are only read after being written
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/fsic_io_serdes_tx.sv
// fsic_io_serdes_tx: buffers parallel words and serializes them LSB-first with a forwarded clock enable
module fsic_io_serdes_tx
    import fsic_io_serdes_pkg::*;
#(
    parameter int                    pCLK_RATIO    = CLK_RATIO_DEFAULT,
    parameter int                    pTxFIFO_DEPTH = TXFIFO_DEPTH_DEFAULT,
    parameter logic [pCLK_RATIO-1:0] pIDLE_WORD    = pCLK_RATIO'(IDLE_WORD_DEFAULT)
) (
    input  logic                          ioclk,
    input  logic                          axis_rst,
    input  logic                          txen,
    input  logic [pCLK_RATIO-1:0]         txdata_in,
    input  logic                          txdata_in_valid,
    output logic                          txdata_in_ready,
    output logic                          Serial_Data_out,
    output logic                          txclk_en,
    output logic [$clog2(pCLK_RATIO)-1:0] tx_phase,
    output logic                          tx_underrun
);

    localparam int PW = $clog2(pCLK_RATIO);
    localparam logic [PW-1:0] LAST_PHASE = PW'(pCLK_RATIO - 1);

    tx_state_e               state_q, state_d;
    logic [PW-1:0]           phase_q, phase_d;
    logic [pCLK_RATIO-1:0]   shift_q, shift_d;
    logic                    sdo_q, sdo_d;
    logic                    clk_en_q, clk_en_d;
    logic                    underrun_q, underrun_d;

    logic                    fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [pCLK_RATIO-1:0]   fifo_dout, load_word, src_word;
    logic                    last_phase, load;

    assign last_phase      = phase_q == LAST_PHASE;
    assign load            = (state_q == RUN) && last_phase;
    assign load_word       = fifo_empty ? pIDLE_WORD : fifo_dout;
    assign src_word        = load ? load_word : shift_q;
    assign txdata_in_ready = !fifo_full && !axis_rst;
    assign fifo_push       = txdata_in_valid && txdata_in_ready;
    assign fifo_pop        = load && !fifo_empty;

    assign Serial_Data_out = sdo_q;
    assign txclk_en        = clk_en_q;
    assign tx_phase        = phase_q;
    assign tx_underrun     = underrun_q;

    fsic_io_serdes_tx_fifo #(
        .pWIDTH (pCLK_RATIO),
        .pDEPTH (pTxFIFO_DEPTH)
    ) u_fifo (
        .clk   (ioclk),
        .rst   (axis_rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (txdata_in),
        .full  (fifo_full),
        .empty (fifo_empty),
        .dout  (fifo_dout)
    );

    // Next-state: IDLE parks at the last phase so the first RUN cycle lands on a word boundary;
    // DRAIN finishes the current word and only returns to IDLE once its last bit has been driven
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        shift_d    = shift_q;
        sdo_d      = 1'b0;
        clk_en_d   = 1'b0;
        underrun_d = underrun_q;
        if (state_q == IDLE) begin
            phase_d = LAST_PHASE;
            state_d = txen ? RUN : IDLE;
        end else if (state_q == DRAIN && last_phase) begin
            state_d = IDLE;
        end else begin
            phase_d    = phase_q + PW'(1);
            sdo_d      = src_word[0];
            shift_d    = src_word >> 1;
            clk_en_d   = 1'b1;
            underrun_d = underrun_q || (load && fifo_empty);
            state_d    = txen ? RUN : DRAIN;
        end
    end

    // FSM, phase counter, shift register and registered pad outputs
    always_ff @(posedge ioclk) begin
        if (axis_rst) begin
            state_q    <= IDLE;
            phase_q    <= LAST_PHASE;
            shift_q    <= '0;
            sdo_q      <= 1'b0;
            clk_en_q   <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            shift_q    <= shift_d;
            sdo_q      <= sdo_d;
            clk_en_q   <= clk_en_d;
            underrun_q <= underrun_d;
        end
    end

endmodule

// File: doc/fsic_io_serdes_tx.md
Name: fsic_io_serdes_tx

Overview:
- Transmit half of the FSIC IO serdes. It accepts pCLK_RATIO-bit parallel words from the core-side valid/ready interface and buffers them in a small FIFO.
- Each word is serialized LSB-first onto one pad bit, one bit per ioclk cycle.
- It also produces a clock-forward enable so the pad-side clock toggles only while real bit slots are driven.
- The far-end receiver rebuilds words LSB-to-MSB from the contiguous bit stream, so word boundaries are implied by continuity from the first forwarded edge.

Parameters:
- pCLK_RATIO, 4, serial bits per parallel word (ioclk/coreclk ratio); power of 2, ≥2.
- pTxFIFO_DEPTH, 2, number of word entries in the input holding FIFO; ≥2.
- pIDLE_WORD, 0, pCLK_RATIO-bit filler word sent on underrun.

Ports:
- ioclk  input  1  sole clock; all state updates on posedge.
- axis_rst  input  1  synchronous, active-high reset.
- txen  input  1  transmit enable.
- txdata_in  input  pCLK_RATIO  parallel word; bit 0 is sent first.
- txdata_in_valid  input  1  word valid.
- txdata_in_ready  output  1  FIFO can accept a word.
- Serial_Data_out  output  1  registered serial bit to pad.
- txclk_en  output  1  registered forward-clock enable, aligned with Serial_Data_out.
- tx_phase  output  $clog2(pCLK_RATIO)  index of the bit currently on Serial_Data_out.
- tx_underrun  output  1  sticky flag: a filler word was sent.

Behaviour:
- Interface (already decided): one clock, ioclk; reset axis_rst is synchronous and active-high.
- Reset values:
  - Serial_Data_out=0, txclk_en=0, tx_underrun=0, FIFO empty.
  - Phase counter = pCLK_RATIO-1; tx_phase reports this counter.
  - shift register = 0; state = IDLE.
  - txdata_in_ready = !full && !axis_rst, so it is 0 while reset is high.
- FIFO:
  - Push when txdata_in_valid && txdata_in_ready.
  - Pop only on a load cycle (defined below).
  - Push and pop in the same cycle when not full: occupancy unchanged.
  - No bypass: a word pushed in the load cycle is not eligible for that load.
  - Pointers wrap at pTxFIFO_DEPTH-1 to 0.
- States:
  - IDLE: Serial_Data_out=0, txclk_en=0, phase held at pCLK_RATIO-1. If txen=1, go to RUN.
  - RUN: phase increments every cycle, wrapping pCLK_RATIO-1 to 0. If txen=0, go to DRAIN (same cycle rules still apply).
  - DRAIN: keep shifting out the current word, with no further loads. When phase reaches pCLK_RATIO-1, go to IDLE. If txen returns to 1 during DRAIN, go back to RUN; the next boundary performs a normal load.
- Load cycle: state == RUN and phase == pCLK_RATIO-1. The first RUN cycle is always a load.
  - FIFO non-empty: pop word w; Serial_Data_out <= w[0]; shift <= w >> 1.
  - FIFO empty: use pIDLE_WORD in the same way and set tx_underrun=1. It stays set until axis_rst.
- Non-load cycle in RUN/DRAIN: Serial_Data_out <= shift[0]; shift <= shift >> 1.
- txclk_en:
  - Registered 1 on every cycle in which Serial_Data_out holds a valid bit slot: from the first load through the last bit of the final word.
  - Drops to 0 on the edge where the block returns to IDLE.
- Latency:
  - txen sampled at edge 0 → RUN; load at edge 1; bit0 is on the pad after edge 1.
  - Bit k is on the pad after edge 1+k.
  - Words go out back-to-back with no gap bits.
- Reset mid-word: the partial word is discarded, the FIFO is flushed, and outputs return to reset values on the next edge.

Decomposition:
- Shared package fsic_io_serdes_pkg:
  - pCLK_RATIO default value.
  - State encoding: IDLE=2'd0, RUN=2'd1, DRAIN=2'd2.
  - Default idle word.
- Sub-module fsic_io_serdes_tx_fifo:
  - Synchronous FIFO, width pCLK_RATIO, depth pTxFIFO_DEPTH.
  - Signals: push, pop, full, empty, dout.
- The top level holds the FSM, phase counter and shift register.

Test Plan:
1. Reset, push 4'b1011, then txen=1 → Serial_Data_out 1,1,0,1 after edges 1..4; txclk_en=1 on those cycles; tx_phase 0,1,2,3; tx_underrun=0.
2. Push 4'hA, 4'h5, 4'hF, holding txen=1 → continuous 0,1,0,1, 1,0,1,0, 1,1,1,1 with no gap; ready drops while the FIFO holds 2 words and reasserts after the first pop.
3. txen=1 with the FIFO empty → four 0 bits, tx_underrun=1 and stays 1 after a later valid word 4'h3, which is sent as 1,1,0,0.
4. Drop txen at phase 1 of word 4'hC → remaining bits 1,1 sent, then IDLE, txclk_en=0; the queued word is untouched and sent on the next txen.
5. Assert axis_rst at phase 2 with 2 words queued → next edge: Serial_Data_out=0, txclk_en=0, ready=0; after release ready=1, FIFO empty.
6. Push with valid held while full for 3 cycles → no overwrite; the pushed order is preserved on the serial output.
